// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - Bring-up signal bundle between the reset sequencer and the board.
//
// Purpose: groups the PLL handshake and downstream reset/status lines of the
// reset sequencer so that they travel as one port.
// Ports (signals):
//   pll_locked  PLL lock indication, asynchronous to the sequencer clock
//   pll_rst     PLL areset, active high
//   dom_rst_n   per-domain resets, active low, bit 0 released first
//   seq_done    high while every domain is running
//   lock_err    sticky, PLL never locked within the retry budget
//   lock_lost   sticky, lock dropped after it had been accepted
//   retry_cnt   number of lock timeouts taken in the current attempt
// Modports: master = sequencer side, slave = board / observer side.

interface reset_sequencer_if #(
  parameter int N_DOM     = 3,
  parameter int MAX_RETRY = 3
);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic             pll_locked;
  logic             pll_rst;
  logic [N_DOM-1:0] dom_rst_n;
  logic             seq_done;
  logic             lock_err;
  logic             lock_lost;
  logic [RW-1:0]    retry_cnt;

  modport master (
    input  pll_locked,
    output pll_rst, dom_rst_n, seq_done, lock_err, lock_lost, retry_cnt
  );

  modport slave (
    output pll_locked,
    input  pll_rst, dom_rst_n, seq_done, lock_err, lock_lost, retry_cnt
  );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - Power-up delay, PLL lock qualification and staggered domain reset release.
//
// Purpose: holds the PLL in reset for DELAY_CNT cycles, waits for a filtered
// lock with timeout and retry, then releases N_DOM domain resets STAGE_GAP
// cycles apart. Lock loss after acceptance restarts the whole sequence.
// Ports:
//   clk  board clock
//   rst  asynchronous active-high reset; deassertion is synchronised internally
//   seq  reset_sequencer_if.master (pll_locked in; pll_rst, dom_rst_n,
//        seq_done, lock_err, lock_lost, retry_cnt out)

module reset_sequencer #(
  parameter int N_DOM     = 3,
  parameter int DELAY_CNT = 1000000,
  parameter int LOCK_FILT = 16,
  parameter int LOCK_TO   = 500000,
  parameter int MAX_RETRY = 3,
  parameter int STAGE_GAP = 64
) (
  input  logic                clk,
  input  logic                rst,
  reset_sequencer_if.master   seq
);

  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int CMAX = (DELAY_CNT > LOCK_TO)
                        ? ((DELAY_CNT > STAGE_GAP) ? DELAY_CNT : STAGE_GAP)
                        : ((LOCK_TO > STAGE_GAP) ? LOCK_TO : STAGE_GAP);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int FW   = $clog2(LOCK_FILT + 1);

  typedef enum logic [2:0] {
    DELAY     = 3'd0,
    LOCK_WAIT = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t           state;
  logic             rst_meta, rst_s;
  logic             lock_meta, locked_s;
  logic [CW-1:0]    cnt, cnt_inc;
  logic [FW-1:0]    filt, filt_inc;
  logic             pll_rst_q, done_q, err_q, lost_q;
  logic [N_DOM-1:0] dom_q;
  logic [RW-1:0]    retry_q;

  // Reset asserts immediately, releases two clocks after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_meta <= 1'b1;
      rst_s    <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_s    <= rst_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= seq.pll_locked;
      locked_s  <= lock_meta;
    end
  end

  // One shared cycle counter serves DELAY, LOCK_WAIT timeout and RELEASE gaps.
  always_comb begin
    cnt_inc  = (cnt == CW'(CMAX)) ? cnt : cnt + CW'(1);
    filt_inc = (filt == FW'(LOCK_FILT)) ? filt : filt + FW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DELAY;
      cnt       <= '0;
      filt      <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      lost_q    <= 1'b0;
      retry_q   <= '0;
    end else if (rst_s) begin
      state     <= DELAY;
      cnt       <= '0;
      filt      <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      lost_q    <= 1'b0;
      retry_q   <= '0;
    end else begin
      case (state)
        DELAY: begin
          pll_rst_q <= 1'b1;
          dom_q     <= '0;
          done_q    <= 1'b0;
          if (cnt == CW'(DELAY_CNT - 1)) begin
            state     <= LOCK_WAIT;
            pll_rst_q <= 1'b0;
            cnt       <= '0;
            filt      <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        LOCK_WAIT: begin
          // Acceptance is tested before the timeout so it wins a tie.
          if (locked_s && (filt_inc == FW'(LOCK_FILT))) begin
            state <= RELEASE;
            dom_q <= N_DOM'(1);
            cnt   <= '0;
            filt  <= '0;
          end else if (cnt_inc == CW'(LOCK_TO)) begin
            cnt       <= '0;
            filt      <= '0;
            pll_rst_q <= 1'b1;
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_q <= retry_q + RW'(1);
              state   <= DELAY;
            end else begin
              state <= FAIL;
              err_q <= 1'b1;
            end
          end else begin
            cnt  <= cnt_inc;
            filt <= locked_s ? filt_inc : '0;
          end
        end

        RELEASE, RUN: begin
          if (!locked_s) begin
            state     <= DELAY;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            done_q    <= 1'b0;
            lost_q    <= 1'b1;
            retry_q   <= '0;
            cnt       <= '0;
            filt      <= '0;
          end else if (state == RELEASE) begin
            if (dom_q[N_DOM-1]) begin
              state  <= RUN;
              done_q <= 1'b1;
            end else if (cnt_inc == CW'(STAGE_GAP)) begin
              // dom_q is a thermometer code: shifting in the next ones bit
              // releases the next domain.
              dom_q <= dom_q | (dom_q << 1);
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end

        FAIL: begin
          pll_rst_q <= 1'b1;
          dom_q     <= '0;
          done_q    <= 1'b0;
          err_q     <= 1'b1;
        end

        default: begin
          state     <= DELAY;
          pll_rst_q <= 1'b1;
          dom_q     <= '0;
          done_q    <= 1'b0;
          cnt       <= '0;
          filt      <= '0;
        end
      endcase
    end
  end

  assign seq.pll_rst   = pll_rst_q;
  assign seq.dom_rst_n = dom_q;
  assign seq.seq_done  = done_q;
  assign seq.lock_err  = err_q;
  assign seq.lock_lost = lost_q;
  assign seq.retry_cnt = retry_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - Directed self-checking bench for reset_sequencer.

module tb_reset_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  reset_sequencer_if #(.N_DOM(3), .MAX_RETRY(2)) sif ();

  reset_sequencer #(
    .N_DOM(3), .DELAY_CNT(8), .LOCK_FILT(4),
    .LOCK_TO(32), .MAX_RETRY(2), .STAGE_GAP(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .seq (sif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [8:0] ev(input logic p, input logic [2:0] d,
                                    input logic s, input logic e,
                                    input logic l, input logic [1:0] r);
    return {p, d, s, e, l, r};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Observed vector: {pll_rst, dom_rst_n[2:0], seq_done, lock_err, lock_lost, retry_cnt[1:0]}
  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {sif.pll_rst, sif.dom_rst_n, sif.seq_done, sif.lock_err,
           sif.lock_lost, sif.retry_cnt};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    sif.pll_locked = 1'b0;
    cyc(3);
    chk("reset_state", ev(1, 3'b000, 0, 0, 0, 0));

    // Normal bring-up, then lock loss in RUN
    rst = 1'b0;
    cyc(9);  chk("n_delay_hi",   ev(1, 3'b000, 0, 0, 0, 0));
    cyc(1);  chk("n_delay_end",  ev(0, 3'b000, 0, 0, 0, 0));
    sif.pll_locked = 1'b1;
    cyc(5);  chk("n_pre_rel",    ev(0, 3'b000, 0, 0, 0, 0));
    cyc(1);  chk("n_dom0",       ev(0, 3'b001, 0, 0, 0, 0));
    cyc(4);  chk("n_dom0_hold",  ev(0, 3'b001, 0, 0, 0, 0));
    cyc(1);  chk("n_dom1",       ev(0, 3'b011, 0, 0, 0, 0));
    cyc(4);  chk("n_dom1_hold",  ev(0, 3'b011, 0, 0, 0, 0));
    cyc(1);  chk("n_dom2",       ev(0, 3'b111, 0, 0, 0, 0));
    cyc(1);  chk("n_run",        ev(0, 3'b111, 1, 0, 0, 0));
    cyc(3);
    sif.pll_locked = 1'b0;
    cyc(2);  chk("l_sync_lat",   ev(0, 3'b111, 1, 0, 0, 0));
    cyc(1);  chk("l_lost",       ev(1, 3'b000, 0, 0, 1, 0));
    sif.pll_locked = 1'b1;
    cyc(7);  chk("l_delay_hi",   ev(1, 3'b000, 0, 0, 1, 0));
    cyc(1);  chk("l_delay_end",  ev(0, 3'b000, 0, 0, 1, 0));
    cyc(3);  chk("l_pre_rel",    ev(0, 3'b000, 0, 0, 1, 0));
    cyc(1);  chk("l_dom0",       ev(0, 3'b001, 0, 0, 1, 0));
    cyc(11); chk("l_run",        ev(0, 3'b111, 1, 0, 1, 0));

    // Glitchy lock
    rst = 1'b1;
    sif.pll_locked = 1'b0;
    cyc(2);  chk("g_reset",      ev(1, 3'b000, 0, 0, 0, 0));
    rst = 1'b0;
    cyc(10); chk("g_delay_end",  ev(0, 3'b000, 0, 0, 0, 0));
    sif.pll_locked = 1'b1;
    cyc(3);
    sif.pll_locked = 1'b0;
    cyc(1);
    sif.pll_locked = 1'b1;
    cyc(2);  chk("g_no_early",   ev(0, 3'b000, 0, 0, 0, 0));
    cyc(3);  chk("g_filt3",      ev(0, 3'b000, 0, 0, 0, 0));
    cyc(1);  chk("g_dom0",       ev(0, 3'b001, 0, 0, 0, 0));

    // Retry then lock
    rst = 1'b1;
    sif.pll_locked = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(41); chk("r_pre_to",     ev(0, 3'b000, 0, 0, 0, 0));
    cyc(1);  chk("r_timeout",    ev(1, 3'b000, 0, 0, 0, 1));
    sif.pll_locked = 1'b1;
    cyc(7);  chk("r_delay_hi",   ev(1, 3'b000, 0, 0, 0, 1));
    cyc(1);  chk("r_delay_end",  ev(0, 3'b000, 0, 0, 0, 1));
    cyc(3);  chk("r_pre_rel",    ev(0, 3'b000, 0, 0, 0, 1));
    cyc(1);  chk("r_dom0",       ev(0, 3'b001, 0, 0, 0, 1));
    cyc(11); chk("r_run",        ev(0, 3'b111, 1, 0, 0, 1));

    // Exhaustion
    rst = 1'b1;
    sif.pll_locked = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(42); chk("x_to1",        ev(1, 3'b000, 0, 0, 0, 1));
    cyc(40); chk("x_to2",        ev(1, 3'b000, 0, 0, 0, 2));
    cyc(39); chk("x_pre_fail",   ev(0, 3'b000, 0, 0, 0, 2));
    cyc(1);  chk("x_fail",       ev(1, 3'b000, 0, 1, 0, 2));
    sif.pll_locked = 1'b1;
    cyc(50); chk("x_fail_hold",  ev(1, 3'b000, 0, 1, 0, 2));

    // Async reset mid-RELEASE
    rst = 1'b1;
    cyc(2);  chk("a_reset",      ev(1, 3'b000, 0, 0, 0, 0));
    rst = 1'b0;
    cyc(14); chk("a_dom0",       ev(0, 3'b001, 0, 0, 0, 0));
    cyc(5);  chk("a_dom1",       ev(0, 3'b011, 0, 0, 0, 0));
    #2 rst = 1'b1;
    #1 chk("a_async",            ev(1, 3'b000, 0, 0, 0, 0));
    @(negedge clk);
    cyc(1);
    rst = 1'b0;
    cyc(14); chk("a_re_dom0",    ev(0, 3'b001, 0, 0, 0, 0));
    cyc(11); chk("a_re_run",     ev(0, 3'b111, 1, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the board-level reset/PLL bring-up logic.
- Sequences the power-up delay, PLL reset pulse and PLL lock qualification, with timeout and retry.
- Releases N_DOM downstream domain resets in a fixed staggered order.
- Runs on the 50 MHz board clock. Sits between the board reset pin and the PLL, SDRAM controller, OV7670 capture and VGA blocks.
- Adds lock filtering, lock-loss recovery and an error flag.

Parameters:
- N_DOM, 3, number of domain reset outputs released in sequence (1..8)
- DELAY_CNT, 1000000, cycles pll_rst is held high per PLL reset pulse (20 ms at 50 MHz)
- LOCK_FILT, 16, consecutive synchronised-locked cycles required before lock is accepted
- LOCK_TO, 500000, cycles allowed in LOCK_WAIT before a timeout
- MAX_RETRY, 3, PLL reset retries after the first attempt before FAIL
- STAGE_GAP, 64, cycles between successive domain releases (≥1)

Ports:
- clk  in  1  board clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL locked; asynchronous to clk
- pll_rst  out  1  PLL areset, active high
- dom_rst_n  out  N_DOM  per-domain reset, active low; bit 0 released first
- seq_done  out  1  high while in RUN
- lock_err  out  1  sticky; high in FAIL
- lock_lost  out  1  sticky; set on any lock loss after lock was accepted
- retry_cnt  out  $clog2(MAX_RETRY+1)  number of timeouts taken

Behaviour:
- **Internal reset:** rst asserts asynchronously. Deassertion passes through a 2-flop synchroniser (rst_s); all logic is held in reset until rst_s releases.
- **Lock input:** pll_locked passes through a 2-flop synchroniser to give locked_s (2-cycle latency).
- **Reset values:** pll_rst=1, dom_rst_n=0, seq_done=0, lock_err=0, lock_lost=0, retry_cnt=0, state=DELAY, all counters=0.
- **DELAY:**
  - pll_rst=1, dom_rst_n all 0.
  - Counter runs 0..DELAY_CNT-1, then goes to LOCK_WAIT.
  - pll_rst is therefore high for exactly DELAY_CNT cycles in this state.
- **LOCK_WAIT:**
  - pll_rst=0.
  - Filter counter increments while locked_s=1 and clears to 0 on any cycle with locked_s=0.
  - When the filter count reaches LOCK_FILT, go to RELEASE.
  - Timeout counter increments every cycle in this state. At LOCK_TO cycles without acceptance:
    - If retry_cnt < MAX_RETRY: retry_cnt+1, go to DELAY.
    - Otherwise: go to FAIL.
  - If filter acceptance and timeout occur in the same cycle, acceptance wins.
- **RELEASE:**
  - pll_rst=0.
  - dom_rst_n[k] goes high (registered) k*STAGE_GAP cycles after the first RELEASE cycle. Bit 0 goes high on the first RELEASE clock edge.
  - The cycle after bit N_DOM-1 goes high, go to RUN.
  - Once released, bits stay high until lock loss or rst.
- **RUN:** seq_done=1, all dom_rst_n=1. Stays in RUN while locked_s=1.
- **Lock loss** (locked_s=0 in RELEASE or RUN):
  - Next edge: dom_rst_n all 0, seq_done=0, lock_lost=1, go to DELAY.
  - retry_cnt is cleared to 0; lock_lost stays set until rst.
  - Lock loss takes priority over a stage release in the same cycle.
- **FAIL:** pll_rst=1, dom_rst_n all 0, lock_err=1. Exit only via rst.
- **Counters:** width $clog2(max+1), saturating; no wrap-around is reachable.
- **Mid-sequence reset:** rst asserted in any state returns all outputs to reset values immediately (asynchronously).

Test Plan (params: N_DOM=3, DELAY_CNT=8, LOCK_FILT=4, LOCK_TO=32, MAX_RETRY=2, STAGE_GAP=5):
- **Normal bring-up:** Release rst, then hold pll_locked=1 from the end of DELAY → pll_rst high 8 cycles after rst_s; dom_rst_n steps 001, 011, 111 at 0/5/10 cycles after RELEASE entry; seq_done=1 one cycle after 111; retry_cnt=0.
- **Glitchy lock:** pll_locked pulses 1 for 3 cycles, 0 for 1 cycle, then 1 steadily → filter restarts; RELEASE entered 4 synchronised-high cycles after the steady rise, not after the pulse.
- **Retry then lock:** pll_locked=0 through the first LOCK_WAIT, then 1 in the second → one 32-cycle timeout; retry_cnt=1; second pll_rst pulse of 8 cycles; reaches RUN; lock_err=0.
- **Exhaustion:** pll_locked held 0 → three timeouts; retry_cnt=2; FAIL with lock_err=1, pll_rst=1, dom_rst_n=000, held until rst.
- **Lock loss in RUN:** In RUN, drop pll_locked → 3 edges later (2 sync + 1) dom_rst_n=000, seq_done=0, lock_lost=1, pll_rst=1; full sequence repeats when locked returns; lock_lost stays 1.
- **Async reset mid-RELEASE:** Assert rst when dom_rst_n=011 → outputs immediately at reset values without a clock edge; sequence restarts cleanly after deassertion.
